// File: rtl/thermo_seq_if.sv
// Handshake bundle between the thermometer ramp sequencer and its environment.
// The sequencer is the slave; the stimulus/encoder side is the master.
interface thermo_seq_if #(
    parameter int DWELL_W = 8
) ();
    logic               start;
    logic [1:0]         mode;
    logic [DWELL_W-1:0] dwell;
    logic               stop;
    logic [2:0]         y_in;
    logic [6:0]         a;
    logic [2:0]         level;
    logic               busy;
    logic               step;
    logic               done;
    logic               err;

    modport master (
        output start, mode, dwell, stop, y_in,
        input  a, level, busy, step, done, err
    );

    modport slave (
        input  start, mode, dwell, stop, y_in,
        output a, level, busy, step, done, err
    );
endinterface

// File: rtl/thermo_seq_ctrl.sv
// Ramps a thermometer code up/down through levels 0..7 with a programmable dwell
// and checks the encoder's binary result against the current level.
module thermo_seq_ctrl #(
    parameter int DWELL_W  = 8,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    thermo_seq_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [2:0]         level_reg, level_next;
    logic [DWELL_W-1:0] cnt_reg, cnt_next;
    logic [DWELL_W-1:0] dwell_reg, dwell_next;
    logic [1:0]         mode_reg, mode_next;
    logic               busy_reg, busy_next;
    logic               step_reg, step_next;
    logic               done_reg, done_next;
    logic               err_reg, err_next;
    logic               mismatch;
    logic [6:0]         a_dec;

    generate
        if (CHECK_EN) begin : g_check
            assign mismatch = (bus.y_in != level_reg);
        end else begin : g_nocheck
            assign mismatch = 1'b0;
        end
    endgenerate

    // Thermometer decode: bit gi is set when the level exceeds gi.
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_dec
            assign a_dec[gi] = (level_reg > 3'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        level_next = level_reg;
        cnt_next   = cnt_reg;
        dwell_next = dwell_reg;
        mode_next  = mode_reg;
        busy_next  = busy_reg;
        err_next   = err_reg;
        step_next  = 1'b0;
        done_next  = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    // Mode 11 behaves as a single ramp, so fold it at latch time.
                    mode_next  = (bus.mode == 2'b11) ? 2'b00 : bus.mode;
                    dwell_next = bus.dwell;
                    cnt_next   = bus.dwell;
                    level_next = 3'd0;
                    err_next   = 1'b0;
                    busy_next  = 1'b1;
                    state_next = S_UP;
                end
            end
            S_UP, S_DOWN: begin
                if (mismatch) begin
                    err_next = 1'b1;
                end
                if (bus.stop) begin
                    state_next = S_IDLE;
                    level_next = 3'd0;
                    cnt_next   = '0;
                    busy_next  = 1'b0;
                end else if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - DWELL_W'(1);
                end else begin
                    cnt_next = dwell_reg;
                    if (state_reg == S_UP) begin
                        if (level_reg != 3'd7) begin
                            level_next = level_reg + 3'd1;
                            step_next  = 1'b1;
                        end else if (mode_reg == 2'b00) begin
                            state_next = S_IDLE;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                        end else begin
                            // Peak level is shown only once per triangle.
                            state_next = S_DOWN;
                            level_next = 3'd6;
                            step_next  = 1'b1;
                        end
                    end else begin
                        if (level_reg != 3'd0) begin
                            level_next = level_reg - 3'd1;
                            step_next  = 1'b1;
                        end else if (mode_reg == 2'b10) begin
                            state_next = S_UP;
                            level_next = 3'd1;
                            step_next  = 1'b1;
                        end else begin
                            state_next = S_IDLE;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                level_next = 3'd0;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            level_reg <= 3'd0;
            cnt_reg   <= '0;
            dwell_reg <= '0;
            mode_reg  <= 2'b00;
            busy_reg  <= 1'b0;
            step_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            level_reg <= level_next;
            cnt_reg   <= cnt_next;
            dwell_reg <= dwell_next;
            mode_reg  <= mode_next;
            busy_reg  <= busy_next;
            step_reg  <= step_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    assign bus.a     = a_dec;
    assign bus.level = level_reg;
    assign bus.busy  = busy_reg;
    assign bus.step  = step_reg;
    assign bus.done  = done_reg;
    assign bus.err   = err_reg;
endmodule

// File: doc/thermo_seq_ctrl.md
Name: thermo_seq_ctrl

Overview:
- Sequencer that drives the 7-bit thermometer-code input of the thermometer-to-binary encoder (Q6_2) through programmable ramp patterns.
- Checks the encoder's 3-bit result against the expected level every active cycle.
- Sits beside the encoder and replaces hand-written stimulus sequencing.
- Used as an on-chip self-test and bar-level pattern generator.

Parameters:
- DWELL_W, 8: width of the dwell input; each level is held dwell+1 cycles.
- CHECK_EN, 1: 1 enables the encoder result compare; 0 forces err to 0.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new sequence; sampled only in IDLE.
- mode  input  2  00 single ramp up, 01 one triangle, 10 continuous triangle, 11 treated as 00.
- dwell  input  DWELL_W  hold count per level; sampled on start acceptance.
- stop  input  1  synchronous abort.
- y_in  input  3  encoder output (combinational from a).
- a  output  7  thermometer code to the encoder; a = (1<<level)-1.
- level  output  3  current expected level, 0..7.
- busy  output  1  high in UP and DOWN.
- step  output  1  one-cycle pulse on every level change.
- done  output  1  one-cycle pulse on normal completion.
- err  output  1  sticky mismatch flag.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, a=0, level=0, busy=0, step=0, done=0, err=0, dwell counter=0.
- States: IDLE, UP, DOWN. All outputs are registered; a is decoded from the level register.
- IDLE:
  - If start=1 at an edge: latch mode and dwell, level<=0, counter<=dwell, err<=0, state<=UP, busy<=1.
  - start is ignored in UP and DOWN.
- Dwell timing:
  - Each level is held exactly dwell+1 cycles.
  - When the counter is 0 at an edge, the level advances, the counter reloads with the latched dwell, and step pulses in the cycle the new level appears.
  - Otherwise the counter decrements.
- UP:
  - Level increments 0→7.
  - When level 7's hold expires:
    - mode 00: state<=IDLE, done=1 for one cycle, a holds 7F until the next start.
    - mode 01/10: state<=DOWN, level<=6 (peak not repeated).
- DOWN:
  - Level decrements 6→0.
  - When level 0's hold expires:
    - mode 01: IDLE, done pulse, a=0.
    - mode 10: UP, level<=1 (trough not repeated), no done pulse.
- Sequence lengths:
  - Single ramp: 8*(dwell+1) cycles from start acceptance to the done edge.
  - Triangle: 15*(dwell+1) cycles.
- stop:
  - In UP/DOWN, stop=1 at an edge gives: state<=IDLE, level<=0, a<=0, busy<=0, no done, err retained.
  - stop in IDLE has no effect.
  - If start and stop are both high in IDLE, start wins.
- Compare (CHECK_EN=1):
  - Every cycle with busy=1, if y_in != level then err<=1 at that edge.
  - err stays set until the next start acceptance or reset.
  - No compare in IDLE.
- Reset mid-operation: immediate return to reset values, independent of clk.
- dwell or mode changes while busy have no effect; the latched values are used.

Test Plan:
- Single ramp: mode=00, dwell=0, start 1 cycle → a steps 00,01,03,07,0F,1F,3F,7F on consecutive cycles; done pulses 8 cycles after acceptance; a stays 7F; busy falls with done.
- Triangle: mode=01, dwell=2 → each level held 3 cycles; sequence 0..7..0 with 7 appearing once; done after 45 cycles; 14 step pulses; final a=00.
- Continuous and stop: mode=10, dwell=0 → a reaches 00 and then 01 with no done pulse. Assert stop while level=4 → next cycle a=00, busy=0, done never pulses.
- Start while busy: pulse start again during UP at level 3 → sequence unaffected; completion timing unchanged.
- Mismatch: force y_in=3'b000 while level=3 → err=1 from the next edge and stays set through completion; a new start clears err to 0.
- Reset mid-run: drop rst_n at level 5 between clock edges → a=00, level=0, busy=0, err=0 immediately; after release, IDLE until start.
